dsp_chain_sop2_feeder: RTL and testbench

//  Operand sequencer and result collector for the 2-deep fp16 sop2 DSP chain.
//  - Accepts packed 8x fp16 operand bundles over valid/ready.
//  - Buffers them and issues one bundle per cycle to the chain's top/bot operand buses.
//  - Tracks the fixed chain latency and captures the fp32 chain result into an output FIFO with valid/ready.
//  - Credit-based issue ensures no result is ever dropped.

---
 rtl/dsp_chain_pkg.sv | 25 ++
 rtl/dsp_feeder_fifo.sv | 49 ++++
 rtl/dsp_chain_sop2_feeder.sv | 155 +++++++++++++++
 tb/tb_dsp_chain_sop2_feeder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_chain_pkg.sv
// rtl/dsp_chain_pkg.sv - shared widths and types for the fp16 sop2 chain feeder
package dsp_chain_pkg;

  localparam int FP16_W  = 16;
  localparam int FP32_W  = 32;
  localparam int SOP_OPS = 8;

  // First member lands in the MSBs, so top_a1 occupies bits [15:0].
  typedef struct packed {
    logic [FP16_W-1:0] bot_b2;
    logic [FP16_W-1:0] bot_a2;
    logic [FP16_W-1:0] top_b2;
    logic [FP16_W-1:0] top_a2;
    logic [FP16_W-1:0] bot_b1;
    logic [FP16_W-1:0] bot_a1;
    logic [FP16_W-1:0] top_b1;
    logic [FP16_W-1:0] top_a1;
  } sop2_bundle_t;

  typedef struct packed {
    logic valid;
    logic last;
  } chain_tag_t;

endpackage

// File: rtl/dsp_feeder_fifo.sv
// rtl/dsp_feeder_fifo.sv - power-of-two FIFO with extra-MSB pointers
// Push when full and pop when empty are ignored; head data reads 0 while empty.
module dsp_feeder_fifo
  import dsp_chain_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/dsp_chain_sop2_feeder.sv
// rtl/dsp_chain_sop2_feeder.sv - operand sequencer and result collector for the sop2 chain
// Optional performance counters are enabled with `define DSP_FEEDER_PERF_EN.
module dsp_chain_sop2_feeder
  import dsp_chain_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int CHAIN_LAT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SOP_OPS*FP16_W-1:0] in_data,
  input  logic                      in_last,
  output logic [FP16_W-1:0]         top_a1,
  output logic [FP16_W-1:0]         top_b1,
  output logic [FP16_W-1:0]         bot_a1,
  output logic [FP16_W-1:0]         bot_b1,
  output logic [FP16_W-1:0]         top_a2,
  output logic [FP16_W-1:0]         top_b2,
  output logic [FP16_W-1:0]         bot_a2,
  output logic [FP16_W-1:0]         bot_b2,
  input  logic [FP32_W-1:0]         chain_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FP32_W-1:0]         out_data,
  output logic                      out_last
`ifdef DSP_FEEDER_PERF_EN
  ,
  output logic [31:0]               perf_in_stall,
  output logic [31:0]               perf_credit_stall,
  output logic [31:0]               perf_issued
`endif
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [IAW:0] IN_FULL  = IN_DEPTH[IAW:0];
  localparam logic [OAW:0] OUT_FULL = OUT_DEPTH[OAW:0];

  logic                      in_ready_q, in_ready_d;
  sop2_bundle_t              ops_q, ops_d;
  logic [OAW:0]              credit_q, credit_d;
  chain_tag_t                tag_q [CHAIN_LAT];
  chain_tag_t                tag_in;

  logic                      in_push;
  logic                      issue;
  logic                      in_empty;
  logic                      in_full_unused;
  logic [IAW:0]              in_count;
  logic [IAW:0]              in_count_nxt;
  logic [SOP_OPS*FP16_W:0]   in_head;
  sop2_bundle_t              head_bundle;
  logic                      head_last;

  logic                      out_pop;
  logic                      out_empty;
  logic                      out_full_unused;
  logic [OAW:0]              out_count_unused;
  logic [FP32_W:0]           out_head;

  assign in_push                 = in_valid && in_ready_q;
  assign {head_last, head_bundle} = in_head;
  assign out_pop                 = !out_empty && out_ready;

  dsp_feeder_fifo #(.WIDTH(SOP_OPS*FP16_W+1), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (in_push),
    .push_data_i ({in_last, in_data}),
    .pop_i       (issue),
    .pop_data_o  (in_head),
    .full_o      (in_full_unused),
    .empty_o     (in_empty),
    .count_o     (in_count)
  );

  // Credit covers every result slot, so this push can never find the FIFO full.
  dsp_feeder_fifo #(.WIDTH(FP32_W+1), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (tag_q[CHAIN_LAT-1].valid),
    .push_data_i ({tag_q[CHAIN_LAT-1].last, chain_result}),
    .pop_i       (out_pop),
    .pop_data_o  (out_head),
    .full_o      (out_full_unused),
    .empty_o     (out_empty),
    .count_o     (out_count_unused)
  );

  always_comb begin
    issue        = !in_empty && (credit_q < OUT_FULL);
    in_count_nxt = in_count + {{IAW{1'b0}}, in_push} - {{IAW{1'b0}}, issue};
    in_ready_d   = (in_count_nxt != IN_FULL);
    ops_d        = issue ? head_bundle : '0;
    credit_d     = credit_q + {{OAW{1'b0}}, issue} - {{OAW{1'b0}}, out_pop};
    tag_in.valid = issue;
    tag_in.last  = head_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q <= 1'b0;
      ops_q      <= '0;
      credit_q   <= '0;
      for (int i = 0; i < CHAIN_LAT; i++) tag_q[i] <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      ops_q      <= ops_d;
      credit_q   <= credit_d;
      tag_q[0]   <= tag_in;
      for (int i = 1; i < CHAIN_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign in_ready  = in_ready_q;
  assign top_a1    = ops_q.top_a1;
  assign top_b1    = ops_q.top_b1;
  assign bot_a1    = ops_q.bot_a1;
  assign bot_b1    = ops_q.bot_b1;
  assign top_a2    = ops_q.top_a2;
  assign top_b2    = ops_q.top_b2;
  assign bot_a2    = ops_q.bot_a2;
  assign bot_b2    = ops_q.bot_b2;
  assign out_valid = !out_empty;
  assign {out_last, out_data} = out_head;

`ifdef DSP_FEEDER_PERF_EN
  logic [31:0] perf_in_stall_q;
  logic [31:0] perf_credit_stall_q;
  logic [31:0] perf_issued_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_in_stall_q     <= '0;
      perf_credit_stall_q <= '0;
      perf_issued_q       <= '0;
    end else begin
      if (in_valid && !in_ready_q && perf_in_stall_q != '1)
        perf_in_stall_q <= perf_in_stall_q + 32'd1;
      if (!in_empty && credit_q == OUT_FULL && perf_credit_stall_q != '1)
        perf_credit_stall_q <= perf_credit_stall_q + 32'd1;
      if (issue && perf_issued_q != '1)
        perf_issued_q <= perf_issued_q + 32'd1;
    end
  end

  assign perf_in_stall     = perf_in_stall_q;
  assign perf_credit_stall = perf_credit_stall_q;
  assign perf_issued       = perf_issued_q;
`endif

endmodule

// File: tb/tb_dsp_chain_sop2_feeder.sv
// tb/tb_dsp_chain_sop2_feeder.sv - randomized self-checking bench for dsp_chain_sop2_feeder
module tb_dsp_chain_sop2_feeder;
  import dsp_chain_pkg::*;

  localparam int IN_DEPTH  = 2;
  localparam int OUT_DEPTH = 8;
  localparam int CHAIN_LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_last;
  logic [127:0] in_data;
  logic [15:0]  top_a1, top_b1, bot_a1, bot_b1, top_a2, top_b2, bot_a2, bot_b2;
  logic [31:0]  chain_result;
  logic         out_valid, out_ready, out_last;
  logic [31:0]  out_data;
`ifdef DSP_FEEDER_PERF_EN
  logic [31:0]  perf_in_stall, perf_credit_stall, perf_issued;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_chain_sop2_feeder #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .CHAIN_LAT(CHAIN_LAT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .top_a1(top_a1), .top_b1(top_b1), .bot_a1(bot_a1), .bot_b1(bot_b1),
    .top_a2(top_a2), .top_b2(top_b2), .bot_a2(bot_a2), .bot_b2(bot_b2),
    .chain_result(chain_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef DSP_FEEDER_PERF_EN
    , .perf_in_stall(perf_in_stall), .perf_credit_stall(perf_credit_stall), .perf_issued(perf_issued)
`endif
  );

  // Chain stand-in: an XOR fold of the operands, valid CHAIN_LAT edges after they are presented.
  function automatic logic [31:0] chain_fn(input sop2_bundle_t b);
    return {b.top_a1 ^ b.top_a2 ^ b.bot_a1 ^ b.bot_a2, b.top_b1 ^ b.top_b2 ^ b.bot_b1 ^ b.bot_b2};
  endfunction

  sop2_bundle_t cur_ops;
  logic [31:0]  pipe [CHAIN_LAT];
  assign cur_ops      = {bot_b2, bot_a2, top_b2, top_a2, bot_b1, bot_a1, top_b1, top_a1};
  assign chain_result = pipe[CHAIN_LAT-1];

  logic [32:0]  exp_q [$];
  logic [32:0]  got_q [$];
  logic [127:0] bq [$];
  int acc_cnt = 0, iss_obs = 0;
  int m_inq = 0, m_credit = 0, m_issued = 0, m_cstall = 0, m_istall = 0;

  initial for (int i = 0; i < CHAIN_LAT; i++) pipe[i] = '0;

  // Handshakes resolve on the next rising edge; everything is stable here.
  always @(negedge clk) begin
    bit m_issue;
    for (int i = CHAIN_LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = chain_fn(cur_ops);
    if (reset) begin
      exp_q.delete(); got_q.delete(); bq.delete();
      acc_cnt = 0; iss_obs = 0;
      m_inq = 0; m_credit = 0; m_issued = 0; m_cstall = 0; m_istall = 0;
    end else begin
      if (top_a1 != 16'h0) iss_obs++;
      m_issue = (m_inq > 0) && (m_credit < OUT_DEPTH);
      if (m_inq > 0 && m_credit == OUT_DEPTH) m_cstall++;
      if (in_valid && !in_ready) m_istall++;
      if (m_issue) m_issued++;
      m_inq    = m_inq + int'(in_valid && in_ready) - int'(m_issue);
      m_credit = m_credit + int'(m_issue) - int'(out_valid && out_ready);
      if (in_valid && in_ready) begin
        exp_q.push_back({chain_fn(in_data), in_last});
        bq.push_back(in_data);
        acc_cnt++;
      end
      if (out_valid && out_ready) got_q.push_back({out_data, out_last});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_rand();
    sop2_bundle_t b;
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.top_a1[0] = 1'b1;
    in_data = b;
    in_last = 1'($urandom_range(0, 1));
  endtask

  task automatic offer(input int n, output int ready_drops);
    int start = acc_cnt;
    int seen  = acc_cnt;
    int guard = 0;
    ready_drops = 0;
    in_valid = 1'b1;
    drive_rand();
    while ((acc_cnt - start) < n && guard < 300) begin
      tick();
      guard++;
      if (acc_cnt != seen) begin
        seen = acc_cnt;
        if ((acc_cnt - start) < n) drive_rand();
      end
      if ((acc_cnt - start) < n && (acc_cnt - start) > 0 && !in_ready) ready_drops++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    int g = 0;
    while (got_q.size() < n && g < budget) begin
      tick();
      g++;
    end
  endtask

  task automatic test_reset();
    int drops, stale;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({in_ready, out_valid, out_last, out_data} !== 35'h0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {in_ready, out_valid, out_last, out_data});
    end
    checks++;
    if (cur_ops !== '0) begin errors++; $display("FAIL reset_operands: got %h required 0", cur_ops); end
    reset = 1'b0;
    tick(); tick();
    out_ready = 1'b1;
    offer(3, drops);
    tick();
    checks++;
    if (acc_cnt != 3) begin errors++; $display("FAIL reset_prefill: got %0d accepts required 3", acc_cnt); end
    reset = 1'b1;
    #1;
    checks++;
    if ({cur_ops, in_ready, out_valid, out_data, out_last} !== '0) begin
      errors++; $display("FAIL reset_async: got ops=%h rdy=%b ov=%b required all 0", cur_ops, in_ready, out_valid);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    stale = 0;
    for (int i = 0; i < 2*CHAIN_LAT; i++) begin
      if (out_valid !== 1'b0) stale++;
      tick();
    end
    checks++;
    if (stale != 0 || got_q.size() != 0) begin
      errors++; $display("FAIL reset_stale: got %0d valid cycles required 0", stale);
    end
  endtask

  task automatic test_single();
    sop2_bundle_t b;
    int first = 0;
    b.top_a1 = 16'h1111; b.top_b1 = 16'h2222; b.bot_a1 = 16'h3333; b.bot_b1 = 16'h4444;
    b.top_a2 = 16'h5555; b.top_b2 = 16'h1234;
    b.bot_a2 = 16'h3F80 ^ b.top_a1 ^ b.bot_a1 ^ b.top_a2;
    b.bot_b2 = b.top_b1 ^ b.bot_b1 ^ b.top_b2;
    out_ready = 1'b0;
    in_data = b; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) in_valid = 1'b0;
      if (k == 2) begin
        checks++;
        if (cur_ops !== b) begin errors++; $display("FAIL single_operands: got %h required %h", cur_ops, b); end
      end
      if (k == 3) begin
        checks++;
        if (cur_ops !== '0) begin errors++; $display("FAIL single_operands_idle: got %h required 0", cur_ops); end
      end
      if (out_valid && first == 0) first = k;
    end
    checks++;
    if (first != 2 + CHAIN_LAT) begin
      errors++; $display("FAIL single_latency: got %0d edges required %0d", first, 2 + CHAIN_LAT);
    end
    checks++;
    if ({out_data, out_last} !== {32'h3F800000, 1'b1}) begin
      errors++; $display("FAIL single_result: got %h/%b required 3f800000/1", out_data, out_last);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got out_valid %b required 0", out_valid); end
    exp_q.delete(); got_q.delete(); bq.delete();
  endtask

  task automatic test_streaming();
    int drops;
    out_ready = 1'b1;
    offer(16, drops);
    checks++;
    if (drops != 0) begin errors++; $display("FAIL stream_in_ready: got %0d drops required 0", drops); end
    wait_got(16, 100);
    checks++;
    if (got_q.size() != 16 || exp_q.size() != 16) begin
      errors++; $display("FAIL stream_count: got %0d results required 16", got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL stream_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete(); got_q.delete(); bq.delete();
  endtask

  task automatic test_backpressure();
    int drops;
    int acc0 = acc_cnt;
    int iss0 = iss_obs;
    out_ready = 1'b0;
    offer(10, drops);
    repeat (4) tick();
    checks++;
    if (acc_cnt - acc0 != OUT_DEPTH + IN_DEPTH) begin
      errors++; $display("FAIL bp_accepts: got %0d required %0d", acc_cnt - acc0, OUT_DEPTH + IN_DEPTH);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
    checks++;
    if (iss_obs - iss0 != OUT_DEPTH) begin
      errors++; $display("FAIL bp_issues: got %0d required %0d", iss_obs - iss0, OUT_DEPTH);
    end
    checks++;
    if (out_valid !== 1'b1 || got_q.size() != 0) begin
      errors++; $display("FAIL bp_hold: got out_valid %b popped %0d required 1/0", out_valid, got_q.size());
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (cur_ops !== '0) begin errors++; $display("FAIL simul_no_early_issue: got %h required 0", cur_ops); end
    tick();
    checks++;
    if (bq.size() < OUT_DEPTH + 1 || cur_ops !== bq[OUT_DEPTH]) begin
      errors++; $display("FAIL simul_issue: got %h required bundle %0d", cur_ops, OUT_DEPTH + 1);
    end
    tick();
    checks++;
    if (cur_ops !== '0) begin errors++; $display("FAIL simul_credit_full: got %h required 0", cur_ops); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    wait_got(10, 200);
    checks++;
    if (got_q.size() != 10 || exp_q.size() != 10) begin
      errors++; $display("FAIL drain_count: got %0d results required 10", got_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL drain_data[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got out_valid %b required 0", out_valid); end
`ifdef DSP_FEEDER_PERF_EN
    checks++;
    if (perf_issued !== 32'(m_issued)) begin
      errors++; $display("FAIL perf_issued: got %0d required %0d", perf_issued, m_issued);
    end
    checks++;
    if (perf_credit_stall !== 32'(m_cstall) || m_cstall == 0) begin
      errors++; $display("FAIL perf_credit_stall: got %0d required %0d", perf_credit_stall, m_cstall);
    end
    checks++;
    if (perf_in_stall !== 32'(m_istall)) begin
      errors++; $display("FAIL perf_in_stall: got %0d required %0d", perf_in_stall, m_istall);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000 required finished");
    $fatal(1);
  end

endmodule
